// File: rtl/interrupt_ack_control_if.sv
// Bus bundle between the CPU/INTA side, the priority resolver and the in-service register.
// fsm_state is a debug view of the acknowledge sequencer.
interface interrupt_ack_control_if;
    logic       inta_n;
    logic [7:0] interrupt_request;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_cmd;
    logic [7:0] highest_level_in_service;
    logic       int_out;
    logic       in_service_flag;
    logic [7:0] interrupt;
    logic [7:0] eoi;
    logic [7:0] data_out;
    logic       data_out_en;
    logic [2:0] fsm_state;

    modport slave (
        input  inta_n, interrupt_request, vector_base, auto_eoi, eoi_cmd,
               highest_level_in_service,
        output int_out, in_service_flag, interrupt, eoi, data_out, data_out_en,
               fsm_state
    );

    modport master (
        output inta_n, interrupt_request, vector_base, auto_eoi, eoi_cmd,
               highest_level_in_service,
        input  int_out, in_service_flag, interrupt, eoi, data_out, data_out_en,
               fsm_state
    );
endinterface

// File: rtl/interrupt_ack_control.sv
// 8259-style INT/INTA acknowledge sequencer with vector generation and EOI masks.
// Optional automatic EOI on the second INTA is enabled by defining PIC_AUTO_EOI_EN.
module interrupt_ack_control (
    input  logic                     clk,
    input  logic                     rst_n,
    interrupt_ack_control_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       inta_q;
    logic       armed;
    logic       inta_fall;
    logic       inta_rise;
    logic       spurious;
    logic       isf_q;
    logic [7:0] interrupt_q;
    logic [7:0] eoi_q;
    logic [7:0] aeoi_mask;

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) r = 3'(i);
        end
        return r;
    endfunction

    // INTA handshake: int_out rises when a request is seen, the first INTA low
    // latches the level, the second INTA low reads the vector, its rise ends it.
    // armed keeps the first sample after reset from counting as an edge.
    assign inta_fall = armed & inta_q & ~bus.inta_n;
    assign inta_rise = armed & ~inta_q & bus.inta_n;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (|bus.interrupt_request) state_next = REQ;
            REQ:  if (inta_fall)              state_next = ACK1;
            ACK1: if (inta_rise)              state_next = GAP;
            GAP:  if (inta_fall)              state_next = ACK2;
            ACK2: if (inta_rise)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

`ifdef PIC_AUTO_EOI_EN
    always_comb begin
        aeoi_mask = 8'h00;
        if (state == ACK2 && inta_rise && bus.auto_eoi && !spurious)
            aeoi_mask = interrupt_q;
    end
`else
    logic unused_auto_eoi;
    assign unused_auto_eoi = bus.auto_eoi;
    assign aeoi_mask       = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            inta_q      <= 1'b1;
            armed       <= 1'b0;
            spurious    <= 1'b0;
            isf_q       <= 1'b0;
            interrupt_q <= 8'h00;
            eoi_q       <= 8'h00;
        end else begin
            state  <= state_next;
            inta_q <= bus.inta_n;
            armed  <= 1'b1;
            isf_q  <= 1'b0;
            eoi_q  <= (bus.eoi_cmd ? bus.highest_level_in_service : 8'h00) | aeoi_mask;
            // A request withdrawn before the first INTA is answered as IR7.
            if (state == REQ && inta_fall) begin
                if (|bus.interrupt_request) begin
                    interrupt_q <= bus.interrupt_request;
                    isf_q       <= 1'b1;
                    spurious    <= 1'b0;
                end else begin
                    interrupt_q <= 8'h80;
                    spurious    <= 1'b1;
                end
            end
        end
    end

    assign bus.int_out         = (state == REQ);
    assign bus.in_service_flag = isf_q;
    assign bus.interrupt       = interrupt_q;
    assign bus.eoi             = eoi_q;
    assign bus.data_out_en     = (state == ACK2) && !bus.inta_n;
    assign bus.data_out        = bus.data_out_en ? {bus.vector_base, encode(interrupt_q)} : 8'h00;
    assign bus.fsm_state       = state;
endmodule

// File: doc/interrupt_ack_control.md
INTERRUPT_ACK_CONTROL -- requirements
Module: interrupt_ack_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port inta_n, input, 1 bit: CPU interrupt acknowledge, active-low, synchronous to clk.
REQ-004 SHALL have port interrupt_request, input, 8 bits: one-hot highest-priority pending unmasked request from the priority resolver; 0 means none.
REQ-005 SHALL have port vector_base, input, 5 bits: ICW2 T7..T3.
REQ-006 SHALL have port auto_eoi, input, 1 bit: AEOI mode select.
REQ-007 SHALL have port eoi_cmd, input, 1 bit: one-cycle non-specific EOI command strobe (OCW2).
REQ-008 SHALL have port highest_level_in_service, input, 8 bits: one-hot highest in-service level from the in-service register.
REQ-009 SHALL have port int_out, output, 1 bit: INT to CPU, active-high.
REQ-010 SHALL have port in_service_flag, output, 1 bit: one-cycle strobe telling the in-service register to set the bit in interrupt.
REQ-011 SHALL have port interrupt, output, 8 bits: latched one-hot acknowledged level.
REQ-012 SHALL have port eoi, output, 8 bits: one-cycle one-hot in-service clear mask.
REQ-013 SHALL have port data_out, output, 8 bits: vector byte.
REQ-014 SHALL have port data_out_en, output, 1 bit: data_out valid/drive enable.

Function
REQ-015 SHALL register inta_n each cycle; falling edge = inta_n 0 and previous sample 1; rising edge = inta_n 1 and previous sample 0.
REQ-016 SHALL implement FSM states IDLE, REQ, ACK1, GAP, ACK2.
REQ-017 IDLE: SHALL go to REQ and assert int_out on the next cycle when interrupt_request is nonzero.
REQ-018 REQ: SHALL hold int_out high and, on a falling edge of inta_n, latch interrupt = interrupt_request, then go to ACK1.
REQ-019 REQ: if interrupt_request is 0 at the first falling edge (withdrawn request), SHALL latch interrupt = 8'h80 (spurious IR7), SHALL NOT pulse in_service_flag, and SHALL still complete the sequence.
REQ-020 SHALL pulse in_service_flag for exactly one cycle, on the cycle after the first falling edge, with interrupt already valid; SHALL deassert int_out in that same cycle.
REQ-021 ACK1: SHALL go to GAP on a rising edge of inta_n; GAP: SHALL go to ACK2 on the next falling edge.
REQ-022 ACK2: SHALL drive data_out = {vector_base, encoded 3-bit level of interrupt} with data_out_en high while inta_n is low; SHALL drive data_out_en low in all other states.
REQ-023 ACK2: on a rising edge of inta_n, SHALL return to IDLE; a still-pending request re-enters REQ no earlier than the following cycle.
REQ-024 Changes to interrupt_request after the first falling edge SHALL NOT alter interrupt or the vector of the current sequence.
REQ-025 eoi_cmd SHALL produce eoi = highest_level_in_service for one cycle, on the cycle after the strobe; eoi SHALL be 0 otherwise.
REQ-026 eoi_cmd with highest_level_in_service = 0 SHALL produce eoi = 0.

Reset
REQ-027 rst_n low at a rising clk edge SHALL force IDLE, int_out 0, in_service_flag 0, interrupt 0, eoi 0, data_out 0, data_out_en 0, and the inta_n sample to 1, including mid-sequence.
REQ-028 After reset release, a first-cycle low inta_n SHALL NOT be taken as a falling edge.

Configuration
REQ-029 Macro PIC_AUTO_EOI_EN: when defined and auto_eoi = 1, on the ACK2 rising edge of a non-spurious sequence, SHALL pulse eoi = interrupt for one cycle.
REQ-030 If that AEOI pulse coincides with an eoi_cmd-generated pulse, eoi SHALL be the OR of both masks.
REQ-031 Without PIC_AUTO_EOI_EN, auto_eoi SHALL be ignored and eoi SHALL come only from eoi_cmd.

Verification
REQ-032 Normal ack: vector_base = 5'b01000, interrupt_request = 8'h04, two INTA pulses -> int_out high, one in_service_flag strobe with interrupt = 8'h04, data_out = 8'h42 with data_out_en high during the second INTA.
REQ-033 Spurious: interrupt_request 8'h10 dropped to 0 before the first INTA -> no in_service_flag strobe, interrupt = 8'h80, data_out = 8'h47.
REQ-034 EOI: highest_level_in_service = 8'h04, eoi_cmd pulse -> eoi = 8'h04 for exactly one cycle.
REQ-035 AEOI (macro defined): auto_eoi = 1, interrupt_request = 8'h01 sequence -> eoi = 8'h01 one cycle after the second INTA rises; macro undefined -> eoi stays 0.
REQ-036 Reset in GAP: rst_n low one cycle -> all outputs 0, FSM in IDLE; a new request then completes a full sequence.
REQ-037 Request change: interrupt_request switches 8'h08 -> 8'h02 after the first INTA -> vector still encodes level 3.
